// File: rtl/div_16bit_share_ctrl.sv
// Round-robin shared 16-bit / 8-bit restoring divider for NUM_REQ valid/ready clients.
// One quotient bit per cycle; the response carries the requester ID.
module div_16bit_share_ctrl #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0]  req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_quotient,
  output logic [15:0]           rsp_remainder,
  output logic                  rsp_dbz,
  output logic                  busy
);

  localparam int unsigned A_W   = 16;
  localparam int unsigned B_W   = 8;
  localparam int unsigned REM_W = B_W + 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [A_W-1:0]     quo_q, quo_d;
  logic [B_W-1:0]     rem_q, rem_d;
  logic [B_W-1:0]     div_q, div_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [A_W-1:0]     rsp_quo_q, rsp_quo_d;
  logic [A_W-1:0]     rsp_rem_q, rsp_rem_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic               rsp_dbz_q, rsp_dbz_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] valid_c;
  logic [NUM_REQ-1:0] grant_c;
  logic [ID_W-1:0]    win_c;
  logic               found_c;
  int unsigned        idx_c;
  int unsigned        win_int_c;
  logic [A_W-1:0]     sel_a_c;
  logic [B_W-1:0]     sel_b_c;
  logic [REM_W-1:0]   rem_sh_c;
  logic [REM_W-1:0]   rem_sub_c;
  logic               take_c;

  // Round-robin scan starting at the pointer, wrapping around.
  always_comb begin
    valid_c = rst ? '0 : req_valid;
    grant_c = '0;
    win_c   = '0;
    found_c = 1'b0;
    idx_c   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_c = (32'(ptr_q) + k) % NUM_REQ;
      if (!found_c && valid_c[ID_W'(idx_c)]) begin
        found_c = 1'b1;
        win_c   = ID_W'(idx_c);
      end
    end
    if (found_c) grant_c = NUM_REQ'(1) << win_c;
    win_int_c = 32'(win_c);
    sel_a_c   = req_a[A_W*win_int_c +: A_W];
    sel_b_c   = req_b[B_W*win_int_c +: B_W];
  end

  // Next-state, datapath and response logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    rsp_quo_d = rsp_quo_q;
    rsp_rem_d = rsp_rem_q;
    rsp_id_d  = rsp_id_q;
    rsp_dbz_d = rsp_dbz_q;
    req_ready = '0;
    // 9-bit partial remainder so the shift never overflows.
    rem_sh_c  = {rem_q, quo_q[A_W-1]};
    rem_sub_c = rem_sh_c - {1'b0, div_q};
    take_c    = (rem_sh_c >= {1'b0, div_q});

    case (state_q)
      S_IDLE: begin
        req_ready = grant_c;
        if (found_c) begin
          ptr_d = (win_c == ID_W'(NUM_REQ - 1)) ? '0 : win_c + ID_W'(1);
          if (sel_b_c != '0) begin
            state_d = S_CALC;
            cnt_d   = '0;
            quo_d   = sel_a_c;
            rem_d   = '0;
            div_d   = sel_b_c;
            id_d    = win_c;
          end else begin
            state_d   = S_DONE;
            rsp_quo_d = 16'hFFFF;
            rsp_rem_d = sel_a_c;
            rsp_dbz_d = 1'b1;
            rsp_id_d  = win_c;
          end
        end
      end
      S_CALC: begin
        quo_d = {quo_q[A_W-2:0], take_c};
        rem_d = take_c ? B_W'(rem_sub_c) : B_W'(rem_sh_c);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(A_W - 1)) begin
          state_d   = S_DONE;
          rsp_quo_d = quo_d;
          rsp_rem_d = A_W'(rem_d);
          rsp_dbz_d = 1'b0;
          rsp_id_d  = id_q;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      rsp_quo_q   <= '0;
      rsp_rem_q   <= '0;
      rsp_id_q    <= '0;
      rsp_dbz_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      rsp_quo_q   <= rsp_quo_d;
      rsp_rem_q   <= rsp_rem_d;
      rsp_id_q    <= rsp_id_d;
      rsp_dbz_q   <= rsp_dbz_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_quotient  = rsp_quo_q;
  assign rsp_remainder = rsp_rem_q;
  assign rsp_dbz       = rsp_dbz_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_div_16bit_share_ctrl.sv
// Directed bench for div_16bit_share_ctrl: divisions, divide-by-zero, round robin,
// backpressure, mid-operation reset and a short randomised sweep.
module tb_div_16bit_share_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_quotient;
  logic [15:0] rsp_remainder;
  logic        rsp_dbz;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  div_16bit_share_ctrl #(.NUM_REQ(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_dbz       (rsp_dbz),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int idx);
    int w = 0;
    while (!req_ready[idx] && w < 64) begin
      tick();
      w++;
    end
    check("grant_seen", 32'(req_ready[idx]), 32'd1);
  endtask

  // One request on port idx, response held for 'stall' cycles before rsp_ready rises.
  task automatic do_op(input int idx, input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                       input int elat, input int stall);
    int lat;
    rsp_ready = 1'b0;
    req_a[16*idx +: 16] = a;
    req_b[8*idx +: 8]   = b;
    req_valid = 4'b0;
    req_valid[idx] = 1'b1;
    #1;
    wait_grant(idx);
    check("grant_onehot", 32'(req_ready), 32'(4'b0001 << idx));
    tick();
    req_valid[idx] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(elat));
    check("rsp_id", 32'(rsp_id), 32'(idx));
    check("rsp_q", 32'(rsp_quotient), 32'(eq));
    check("rsp_r", 32'(rsp_remainder), 32'(er));
    check("rsp_dbz", 32'(rsp_dbz), 32'(edbz));
    repeat (stall) begin
      tick();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_q", 32'(rsp_quotient), 32'(eq));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  // Expect the next grant to go to port exp with all other requesters left as driven.
  task automatic rr_step(input int exp);
    int w = 0;
    while (req_ready == 4'b0 && w < 64) begin
      tick();
      w++;
    end
    check("rr_grant", 32'(req_ready), 32'(4'b0001 << exp));
    tick();
    w = 0;
    while (!rsp_valid && w < 40) begin
      tick();
      w++;
    end
    check("rr_id", 32'(rsp_id), 32'(exp));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int vcount;
    logic [15:0] ra;
    logic [7:0]  rb;
    int          ridx;

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q", 32'(rsp_quotient), 32'd0);
    check("rst_r", 32'(rsp_remainder), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_dbz", 32'(rsp_dbz), 32'd0);

    // Basic divisions and divide-by-zero.
    do_op(0, 16'd1000, 8'd7, 16'd142, 16'd6, 1'b0, 17, 0);
    do_op(1, 16'hFFFF, 8'hFF, 16'd257, 16'd0, 1'b0, 17, 0);
    do_op(3, 16'hFFFF, 8'd1, 16'hFFFF, 16'd0, 1'b0, 17, 1);
    do_op(0, 16'd0, 8'd5, 16'd0, 16'd0, 1'b0, 17, 0);
    do_op(1, 16'd3, 8'd200, 16'd0, 16'd3, 1'b0, 17, 0);
    do_op(2, 16'h04D2, 8'd0, 16'hFFFF, 16'h04D2, 1'b1, 1, 2);

    // Round robin with every requester valid from reset.
    rst       = 1'b1;
    req_a     = {16'd40, 16'd30, 16'd20, 16'd10};
    req_b     = {8'd3, 8'd3, 8'd3, 8'd3};
    req_valid = 4'b1111;
    tick();
    check("rst_gated_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    rr_step(0);
    rr_step(1);
    rr_step(2);
    rr_step(3);
    rr_step(0);
    rr_step(1);
    req_valid = 4'b1010;
    #1;
    rr_step(3);
    rr_step(1);
    req_valid = 4'b0;

    // Backpressure with a pending request on port 1.
    rsp_ready = 1'b0;
    req_a[15:0] = 16'd100;
    req_b[7:0]  = 8'd9;
    req_valid   = 4'b0001;
    #1;
    wait_grant(0);
    tick();
    req_valid = 4'b0;
    vcount = 0;
    while (!rsp_valid && vcount < 40) begin
      tick();
      vcount++;
    end
    req_a[31:16] = 16'd50;
    req_b[15:8]  = 8'd5;
    req_valid    = 4'b0010;
    repeat (5) begin
      tick();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_q", 32'(rsp_quotient), 32'd11);
      check("bp_r", 32'(rsp_remainder), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_accept", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0;
    vcount = 0;
    while (!rsp_valid && vcount < 40) begin
      tick();
      vcount++;
    end
    check("bp2_id", 32'(rsp_id), 32'd1);
    check("bp2_q", 32'(rsp_quotient), 32'd10);
    check("bp2_r", 32'(rsp_remainder), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset during CALC cycle 8 aborts the operation.
    req_a[47:32] = 16'd1234;
    req_b[23:16] = 8'd7;
    req_valid    = 4'b0100;
    #1;
    wait_grant(2);
    tick();
    req_valid = 4'b0;
    repeat (7) tick();
    check("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    req_valid = 4'b1111;
    #1;
    check("mid_ptr_zero", 32'(req_ready), 32'b0001);
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    vcount = 0;
    repeat (30) begin
      tick();
      if (rsp_valid) vcount++;
    end
    rsp_ready = 1'b0;
    check("mid_no_rsp", 32'(vcount), 32'd0);

    // Randomised sweep against a reference quotient and remainder.
    for (int i = 0; i < 150; i++) begin
      ridx = $urandom_range(0, 3);
      ra   = 16'($urandom);
      rb   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if (rb == 8'd0)
        do_op(ridx, ra, rb, 16'hFFFF, ra, 1'b1, 1, $urandom_range(0, 3));
      else
        do_op(ridx, ra, rb, ra / {8'd0, rb}, ra % {8'd0, rb}, 1'b0, 17, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
